// File: rtl/program_sequencer_if.sv
// Handshake bundle between the program sequencer, the fetch unit (Init/DONE/Start_addr)
// and the result consumer.
interface program_sequencer_if;
  logic        Start;
  logic        DONE;
  logic        Init;
  logic [15:0] Start_addr;
  logic [3:0]  Prog_id;
  logic        Busy;
  logic        Result_valid;
  logic        Result_ready;
  logic [3:0]  Result_prog;
  logic [31:0] Result_cycles;
  logic        Result_timeout;
  logic        All_done;

  modport master (
    input  Start, DONE, Result_ready,
    output Init, Start_addr, Prog_id, Busy, Result_valid,
           Result_prog, Result_cycles, Result_timeout, All_done
  );

  modport slave (
    output Start, DONE, Result_ready,
    input  Init, Start_addr, Prog_id, Busy, Result_valid,
           Result_prog, Result_cycles, Result_timeout, All_done
  );
endinterface

// File: rtl/program_sequencer.sv
// Steps the fetch unit through NUM_PROGS programs: Init hold, run until DONE or timeout,
// then report the cycle count on a valid/ready port.
module program_sequencer #(
  parameter int                      NUM_PROGS      = 3,
  parameter logic [16*NUM_PROGS-1:0] START_ADDRS    = {16'd301, 16'd124, 16'd66},
  parameter int                      INIT_CYCLES    = 2,
  parameter logic [31:0]             TIMEOUT_CYCLES = 32'd100000
) (
  input logic                 CLK,
  input logic                 Reset_n,
  program_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, REPORT, FINISHED} state_t;

  localparam int             IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0]  INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [3:0]     LAST_PROG = 4'(NUM_PROGS - 1);
  localparam logic [31:0]    CNT_LAST  = TIMEOUT_CYCLES - 32'd1;

  state_t        state;
  logic [IW-1:0] init_cnt;
  logic [31:0]   cycle_cnt;
  logic [3:0]    prog_id;
  logic [3:0]    res_prog;
  logic [31:0]   res_cycles;
  logic          res_timeout;
  logic [15:0]   addr_tab [16];

  // Full 16-entry table so any 4-bit program index selects a defined value.
  for (genvar i = 0; i < 16; i++) begin : g_addr
    if (i < NUM_PROGS) begin : g_used
      assign addr_tab[i] = START_ADDRS[16*i +: 16];
    end else begin : g_unused
      assign addr_tab[i] = 16'd0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      init_cnt    <= '0;
      cycle_cnt   <= '0;
      prog_id     <= '0;
      res_prog    <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISHED: begin
          if (bus.Start) begin
            prog_id  <= '0;
            init_cnt <= '0;
            state    <= INIT;
          end
        end
        INIT: begin
          if (init_cnt == INIT_LAST) begin
            init_cnt  <= '0;
            cycle_cnt <= '0;
            state     <= RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          // DONE takes priority over a timeout landing on the same cycle.
          if (bus.DONE) begin
            res_prog    <= prog_id;
            res_cycles  <= cycle_cnt;
            res_timeout <= 1'b0;
            state       <= REPORT;
          end else if (cycle_cnt == CNT_LAST) begin
            res_prog    <= prog_id;
            res_cycles  <= TIMEOUT_CYCLES;
            res_timeout <= 1'b1;
            state       <= REPORT;
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end
        REPORT: begin
          if (bus.Result_ready) begin
            if (prog_id == LAST_PROG) begin
              state <= FINISHED;
            end else begin
              prog_id  <= prog_id + 4'd1;
              init_cnt <= '0;
              state    <= INIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Init           = (state != RUN);
  assign bus.Busy           = (state == INIT) || (state == RUN) || (state == REPORT);
  assign bus.Result_valid   = (state == REPORT);
  assign bus.All_done       = (state == FINISHED);
  assign bus.Prog_id        = prog_id;
  assign bus.Start_addr     = addr_tab[prog_id];
  assign bus.Result_prog    = res_prog;
  assign bus.Result_cycles  = res_cycles;
  assign bus.Result_timeout = res_timeout;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: one DUT with default parameters and one with
// an 8-cycle timeout; results are compared on each valid/ready handshake.
module tb_program_sequencer;

  typedef struct packed {
    logic [3:0]  prog;
    logic [31:0] cycles;
    logic        timeout;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t q_main[$];
  res_t q_to[$];
  res_t exp_m, exp_t;
  int   addrs[3] = '{66, 124, 301};

  always #5 clk = ~clk;

  program_sequencer_if ifc ();
  program_sequencer_if ift ();

  program_sequencer dut (.CLK(clk), .Reset_n(rst_n), .bus(ifc));
  program_sequencer #(.TIMEOUT_CYCLES(32'd8)) dut_to (.CLK(clk), .Reset_n(rst_n), .bus(ift));

  // Scoreboard monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.Result_valid === 1'b1 && ifc.Result_ready === 1'b1) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL main_result_unexpected: got prog=%0d cycles=%0d timeout=%0b, expected none",
                 ifc.Result_prog, ifc.Result_cycles, ifc.Result_timeout);
      end else begin
        exp_m = q_main.pop_front();
        if ({ifc.Result_prog, ifc.Result_cycles, ifc.Result_timeout} !== exp_m) begin
          errors++;
          $display("FAIL main_result: got prog=%0d cycles=%0d timeout=%0b, expected prog=%0d cycles=%0d timeout=%0b",
                   ifc.Result_prog, ifc.Result_cycles, ifc.Result_timeout,
                   exp_m.prog, exp_m.cycles, exp_m.timeout);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ift.Result_valid === 1'b1 && ift.Result_ready === 1'b1) begin
      checks++;
      if (q_to.size() == 0) begin
        errors++;
        $display("FAIL to_result_unexpected: got prog=%0d cycles=%0d timeout=%0b, expected none",
                 ift.Result_prog, ift.Result_cycles, ift.Result_timeout);
      end else begin
        exp_t = q_to.pop_front();
        if ({ift.Result_prog, ift.Result_cycles, ift.Result_timeout} !== exp_t) begin
          errors++;
          $display("FAIL to_result: got prog=%0d cycles=%0d timeout=%0b, expected prog=%0d cycles=%0d timeout=%0b",
                   ift.Result_prog, ift.Result_cycles, ift.Result_timeout,
                   exp_t.prog, exp_t.cycles, exp_t.timeout);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_run_main();
    int g = 0;
    while (ifc.Init !== 1'b0 && g < 100) begin
      tick();
      g++;
    end
    if (ifc.Init !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL main_wait_run: Init=%b after %0d cycles, expected 0", ifc.Init, g);
    end
  endtask

  task automatic wait_run_to();
    int g = 0;
    while (ift.Init !== 1'b0 && g < 100) begin
      tick();
      g++;
    end
    if (ift.Init !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL to_wait_run: Init=%b after %0d cycles, expected 0", ift.Init, g);
    end
  endtask

  // Called on the first RUN cycle; DONE is raised on RUN cycle n+1 so the count is n.
  task automatic done_after_main(input int n);
    ifc.DONE = 1'b0;
    repeat (n) tick();
    ifc.DONE = 1'b1;
    tick();
    ifc.DONE = 1'b0;
  endtask

  task automatic test_reset();
    ifc.Start = 1'b0; ifc.DONE = 1'b0; ifc.Result_ready = 1'b0;
    ift.Start = 1'b0; ift.DONE = 1'b0; ift.Result_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({ifc.Init, ifc.Prog_id, ifc.Start_addr, ifc.Busy, ifc.Result_valid, ifc.All_done} !==
        {1'b1, 4'd0, 16'd66, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: Init=%b Prog_id=%0d Start_addr=%0d Busy=%b valid=%b All_done=%b, expected 1 0 66 0 0 0",
               ifc.Init, ifc.Prog_id, ifc.Start_addr, ifc.Busy, ifc.Result_valid, ifc.All_done);
    end
    checks++;
    if ({ifc.Result_prog, ifc.Result_cycles, ifc.Result_timeout} !== 37'd0) begin
      errors++;
      $display("FAIL reset_result: prog=%0d cycles=%0d timeout=%b, expected all 0",
               ifc.Result_prog, ifc.Result_cycles, ifc.Result_timeout);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (ifc.Init !== 1'b1 || ifc.Busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: Init=%b Busy=%b, expected 1 0", ifc.Init, ifc.Busy);
    end
  endtask

  task automatic test_single_program();
    int ic = 0;
    ifc.Result_ready = 1'b1;
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    checks++;
    if ({ifc.Init, ifc.Busy, ifc.Prog_id, ifc.Start_addr} !== {1'b1, 1'b1, 4'd0, 16'd66}) begin
      errors++;
      $display("FAIL init_entry: Init=%b Busy=%b Prog_id=%0d Start_addr=%0d, expected 1 1 0 66",
               ifc.Init, ifc.Busy, ifc.Prog_id, ifc.Start_addr);
    end
    while (ifc.Init === 1'b1 && ic < 10) begin
      ic++;
      tick();
    end
    checks++;
    if (ic !== 2) begin
      errors++;
      $display("FAIL init_length: got %0d Init cycles, expected 2", ic);
    end
    q_main.push_back('{prog: 4'd0, cycles: 32'd4, timeout: 1'b0});
    done_after_main(4);
    checks++;
    if ({ifc.Result_valid, ifc.Init, ifc.Result_prog, ifc.Result_cycles} !== {1'b1, 1'b1, 4'd0, 32'd4}) begin
      errors++;
      $display("FAIL report_entry: valid=%b Init=%b prog=%0d cycles=%0d, expected 1 1 0 4",
               ifc.Result_valid, ifc.Init, ifc.Result_prog, ifc.Result_cycles);
    end
    tick();
    checks++;
    if ({ifc.Result_valid, ifc.Prog_id, ifc.Start_addr} !== {1'b0, 4'd1, 16'd124}) begin
      errors++;
      $display("FAIL next_prog: valid=%b Prog_id=%0d Start_addr=%0d, expected 0 1 124",
               ifc.Result_valid, ifc.Prog_id, ifc.Start_addr);
    end
  endtask

  task automatic test_full_run();
    do_reset();
    ifc.Result_ready = 1'b1;
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      wait_run_main();
      checks++;
      if (ifc.Prog_id !== 4'(p) || ifc.Start_addr !== 16'(addrs[p])) begin
        errors++;
        $display("FAIL full_prog%0d: Prog_id=%0d Start_addr=%0d, expected %0d %0d",
                 p, ifc.Prog_id, ifc.Start_addr, p, addrs[p]);
      end
      q_main.push_back('{prog: 4'(p), cycles: 32'(10 * (p + 1)), timeout: 1'b0});
      done_after_main(10 * (p + 1));
      checks++;
      if (ifc.All_done !== 1'b0) begin
        errors++;
        $display("FAIL full_alldone_early%0d: All_done=%b, expected 0", p, ifc.All_done);
      end
      tick();
    end
    checks++;
    if ({ifc.All_done, ifc.Busy, ifc.Init, ifc.Result_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL finished: All_done=%b Busy=%b Init=%b valid=%b, expected 1 0 1 0",
               ifc.All_done, ifc.Busy, ifc.Init, ifc.Result_valid);
    end
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    checks++;
    if ({ifc.All_done, ifc.Busy, ifc.Prog_id} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL restart: All_done=%b Busy=%b Prog_id=%0d, expected 0 1 0",
               ifc.All_done, ifc.Busy, ifc.Prog_id);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ifc.Result_ready = 1'b0;
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    wait_run_main();
    q_main.push_back('{prog: 4'd0, cycles: 32'd3, timeout: 1'b0});
    done_after_main(3);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ifc.Result_valid, ifc.Init, ifc.Result_prog, ifc.Result_cycles, ifc.Result_timeout} !==
          {1'b1, 1'b1, 4'd0, 32'd3, 1'b0}) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b Init=%b prog=%0d cycles=%0d timeout=%b, expected 1 1 0 3 0",
                 i, ifc.Result_valid, ifc.Init, ifc.Result_prog, ifc.Result_cycles, ifc.Result_timeout);
      end
      tick();
    end
    ifc.Result_ready = 1'b1;
    tick();
    checks++;
    if (ifc.Result_valid !== 1'b0 || ifc.Prog_id !== 4'd1) begin
      errors++;
      $display("FAIL stall_release: valid=%b Prog_id=%0d, expected 0 1", ifc.Result_valid, ifc.Prog_id);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    ifc.Result_ready = 1'b1;
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    wait_run_main();
    q_main.push_back('{prog: 4'd0, cycles: 32'd2, timeout: 1'b0});
    done_after_main(2);
    tick();
    wait_run_main();
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    checks++;
    if ({ifc.Init, ifc.Busy, ifc.Prog_id} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL start_ignored: Init=%b Busy=%b Prog_id=%0d, expected 0 1 1",
               ifc.Init, ifc.Busy, ifc.Prog_id);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.Init, ifc.Prog_id, ifc.Result_valid, ifc.Busy, ifc.Start_addr} !==
        {1'b1, 4'd0, 1'b0, 1'b0, 16'd66}) begin
      errors++;
      $display("FAIL async_reset: Init=%b Prog_id=%0d valid=%b Busy=%b Start_addr=%0d, expected 1 0 0 0 66",
               ifc.Init, ifc.Prog_id, ifc.Result_valid, ifc.Busy, ifc.Start_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int k = 0;
    do_reset();
    ift.Result_ready = 1'b0;
    ift.DONE = 1'b0;
    ift.Start = 1'b1;
    tick();
    ift.Start = 1'b0;
    wait_run_to();
    q_to.push_back('{prog: 4'd0, cycles: 32'd8, timeout: 1'b1});
    while (ift.Result_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (k !== 8) begin
      errors++;
      $display("FAIL timeout_length: got %0d RUN cycles, expected 8", k);
    end
    checks++;
    if ({ift.Result_timeout, ift.Result_cycles} !== {1'b1, 32'd8}) begin
      errors++;
      $display("FAIL timeout_result: timeout=%b cycles=%0d, expected 1 8", ift.Result_timeout, ift.Result_cycles);
    end
    ift.Result_ready = 1'b1;
    tick();
    checks++;
    if ({ift.Prog_id, ift.Init, ift.Busy} !== {4'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL timeout_next: Prog_id=%0d Init=%b Busy=%b, expected 1 1 1", ift.Prog_id, ift.Init, ift.Busy);
    end
  endtask

  task automatic test_done_at_timeout();
    wait_run_to();
    ift.DONE = 1'b0;
    repeat (7) tick();
    ift.DONE = 1'b1;
    q_to.push_back('{prog: 4'd1, cycles: 32'd7, timeout: 1'b0});
    tick();
    ift.DONE = 1'b0;
    checks++;
    if ({ift.Result_valid, ift.Result_timeout, ift.Result_cycles} !== {1'b1, 1'b0, 32'd7}) begin
      errors++;
      $display("FAIL done_wins: valid=%b timeout=%b cycles=%0d, expected 1 0 7",
               ift.Result_valid, ift.Result_timeout, ift.Result_cycles);
    end
    tick();
    ift.Result_ready = 1'b0;
    checks++;
    if (ift.Prog_id !== 4'd2) begin
      errors++;
      $display("FAIL done_wins_next: Prog_id=%0d, expected 2", ift.Prog_id);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_program();
    test_full_run();
    test_stall();
    test_reset_mid_run();
    test_timeout();
    test_done_at_timeout();
    tick();
    checks++;
    if (q_main.size() != 0 || q_to.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d results outstanding, expected 0/0", q_main.size(), q_to.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
